// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // One writeback request as presented by a requester.
    typedef struct packed {
        logic                  req;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    // Which requester wins when both ask in the same cycle.
    typedef enum logic {
        PRI_REQ0 = 1'b0,
        PRI_REQ1 = 1'b1
    } prio_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered
// priority pointer that moves to the loser after every grant.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       Clk,
    input  logic       R,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    prio_t ptr;

    // Grant decision for the current cycle; nothing is granted during reset or when disabled.
    always_comb begin
        // NOTE: default assignment first so every path assigns gnt and no latch is inferred.
        gnt = 2'b00;
        if (en && !R) begin
            if (req == 2'b11) begin
                gnt = (ptr == PRI_REQ1) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Priority pointer hands precedence to the requester that did not win.
    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            ptr <= PRI_REQ0;
        end else if (gnt[0]) begin
            ptr <= PRI_REQ1;
        end else if (gnt[1]) begin
            ptr <= PRI_REQ0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the ALU and load
// writeback paths. Writes to x0 are granted but never strobed into the file.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int N      = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              R,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [N-1:0]      data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [N-1:0]      data1,
    output logic              gnt1,
    input  logic              stall,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [N-1:0]      wdata,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [ADDR_W-1:0] X0_ADDR = ADDR_W'(ZERO_REG);

    logic [1:0]        req_vec;
    logic [1:0]        gnt_vec;
    logic [ADDR_W-1:0] win_addr;
    logic [N-1:0]      win_data;

    assign req_vec = {req1, req0};

    rr_arbiter2 u_arb (
        .Clk (Clk),
        .R   (R),
        .req (req_vec),
        .en  (~stall),
        .gnt (gnt_vec)
    );

    assign gnt0 = gnt_vec[0];
    assign gnt1 = gnt_vec[1];
    assign busy = (req0 | req1) & ~(gnt0 | gnt1);

    // Select the winning requester's address and data.
    always_comb begin
        win_addr = addr0;
        win_data = data0;
        if (gnt1) begin
            win_addr = addr1;
            win_data = data1;
        end
    end

    // Register the write one cycle after the grant; x0 writes load the bus but do not strobe.
    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (gnt0 || gnt1) begin
            we    <= (win_addr != X0_ADDR);
            waddr <= win_addr;
            wdata <= win_data;
        end else begin
            we    <= 1'b0;
        end
    end

    // Count strobes actually issued to the register file, holding at the maximum.
    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            wr_count <= '0;
        end else if (we && (wr_count != CNT_MAX)) begin
            wr_count <= wr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a cycle-level reference model.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic    Clk = 1'b0;
    logic    R;
    logic    stall;
    wb_req_t r0, r1;

    logic                  gnt0, gnt1, we, busy;
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_DATA_W-1:0] wdata;
    logic [15:0]           wr_count;

    logic                  s_gnt0, s_gnt1, s_we, s_busy;
    logic [REG_ADDR_W-1:0] s_waddr;
    logic [REG_DATA_W-1:0] s_wdata;
    logic [3:0]            s_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    regfile_write_arbiter dut (
        .Clk(Clk), .R(R),
        .req0(r0.req), .addr0(r0.addr), .data0(r0.data), .gnt0(gnt0),
        .req1(r1.req), .addr1(r1.addr), .data1(r1.data), .gnt1(gnt1),
        .stall(stall), .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .wr_count(wr_count)
    );

    regfile_write_arbiter #(.CNT_W(4)) dut_sat (
        .Clk(Clk), .R(R),
        .req0(r0.req), .addr0(r0.addr), .data0(r0.data), .gnt0(s_gnt0),
        .req1(r1.req), .addr1(r1.addr), .data1(r1.data), .gnt1(s_gnt1),
        .stall(stall), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
        .busy(s_busy), .wr_count(s_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int                    m_prio = 0;
    logic                  m_we = 1'b0;
    logic [REG_ADDR_W-1:0] m_waddr = '0;
    logic [REG_DATA_W-1:0] m_wdata = '0;
    int                    m_cnt = 0;
    int                    m_cnt4 = 0;

    // Which requester transfers this cycle (-1 = none).
    function automatic int winner();
        if (R || stall) return -1;
        if (r0.req && r1.req) return m_prio;
        if (r0.req) return 0;
        if (r1.req) return 1;
        return -1;
    endfunction

    always @(posedge Clk or posedge R) begin
        if (R) begin
            m_prio  <= 0;
            m_we    <= 1'b0;
            m_waddr <= '0;
            m_wdata <= '0;
            m_cnt   <= 0;
            m_cnt4  <= 0;
        end else begin
            if (m_we) begin
                m_cnt  <= (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
                m_cnt4 <= (m_cnt4 < 15)    ? m_cnt4 + 1 : m_cnt4;
            end
            if (winner() == 0) begin
                m_prio  <= 1;
                m_waddr <= r0.addr;
                m_wdata <= r0.data;
                m_we    <= (r0.addr != 0);
            end else if (winner() == 1) begin
                m_prio  <= 0;
                m_waddr <= r1.addr;
                m_wdata <= r1.data;
                m_we    <= (r1.addr != 0);
            end else begin
                m_we <= 1'b0;
            end
        end
    end

    always @(negedge Clk) begin
        check("gnt0",     gnt0,     (winner() == 0));
        check("gnt1",     gnt1,     (winner() == 1));
        check("busy",     busy,     (r0.req | r1.req) && (winner() < 0));
        check("we",       we,       m_we);
        check("waddr",    waddr,    m_waddr);
        check("wdata",    wdata,    m_wdata);
        check("wr_count", wr_count, 64'(m_cnt));
        check("sat_cnt",  s_count,  64'(m_cnt4));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        R = 1'b1;
        stall = 1'b0;
        r0 = '{req: 1'b1, addr: 5'd3, data: 32'd7};
        r1 = '0;

        // Reset holds grants and outputs low even with a request present.
        #2;
        check("rst_gnt0", gnt0, 0);
        check("rst_we",   we, 0);
        check("rst_cnt",  wr_count, 0);
        tick(); tick();
        R = 1'b0;
        #1 check("rel_gnt0", gnt0, 1);
        tick();
        r0.req = 1'b0;
        check("rel_we",    we, 1);
        check("rel_waddr", waddr, 3);
        check("rel_wdata", wdata, 7);

        // Fresh reset, then contention alternates 0,1,0,1.
        R = 1'b1;
        tick();
        R = 1'b0;
        r0 = '{req: 1'b1, addr: 5'd1, data: 32'h11};
        r1 = '{req: 1'b1, addr: 5'd2, data: 32'h22};
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_gnt0", gnt0, (i % 2 == 0));
            check("cont_gnt1", gnt1, (i % 2 == 1));
            tick();
            check("cont_we",    we, 1);
            check("cont_waddr", waddr, (i % 2 == 0) ? 1 : 2);
        end
        r0.req = 1'b0;
        r1.req = 1'b0;
        tick();
        check("cont_cnt",  wr_count, 4);
        check("cont_idle", we, 0);

        // Stall blocks both requesters; pointer holder (req0) goes first afterwards.
        stall = 1'b1;
        r0 = '{req: 1'b1, addr: 5'd4, data: 32'd44};
        r1 = '{req: 1'b1, addr: 5'd6, data: 32'd66};
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_gnt", {gnt1, gnt0}, 0);
            check("stall_busy", busy, 1);
            tick();
            check("stall_we", we, 0);
        end
        stall = 1'b0;
        #1 check("unstall_gnt0", gnt0, 1);
        tick();
        r0.req = 1'b0;
        #1 check("unstall_gnt1", gnt1, 1);
        tick();

        // Write to x0: granted, but no strobe and no count.
        r1 = '{req: 1'b1, addr: 5'd0, data: 32'hFFFF_FFFF};
        #1 check("x0_gnt1", gnt1, 1);
        tick();
        r1.req = 1'b0;
        check("x0_we",    we, 0);
        check("x0_waddr", waddr, 0);
        check("x0_wdata", wdata, 32'hFFFF_FFFF);
        tick();
        check("x0_cnt", wr_count, 6);

        // Asynchronous reset while a write strobe is high.
        r0 = '{req: 1'b1, addr: 5'd7, data: 32'd77};
        r1 = '{req: 1'b1, addr: 5'd8, data: 32'd88};
        #1 check("ar_gnt0", gnt0, 1);
        tick();
        check("ar_we_before", we, 1);
        #1 R = 1'b1;
        #1;
        check("ar_we_async",  we, 0);
        check("ar_cnt_async", wr_count, 0);
        tick();
        R = 1'b0;
        #1 check("ar_first", gnt0, 1);
        tick();
        r0.req = 1'b0;
        #1 check("ar_second", gnt1, 1);
        tick();
        r1.req = 1'b0;

        // Twenty back-to-back writes: the 4-bit counter pins at 15.
        for (int i = 0; i < 20; i++) begin
            r0 = '{req: 1'b1, addr: 5'(i % 31 + 1), data: 32'(i)};
            tick();
        end
        r0.req = 1'b0;
        tick(); tick();
        check("sat_15",   s_count, 15);
        check("cnt_22",   wr_count, 22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
